// File: rtl/window_manager_if.sv
// Register-window manager bundle: control requests in, window state and spill/fill transfer port out.
// Latency: carries no state; every signal is plain wiring between the requester and window_manager.
// Backpressure: SpillReq/FillReq stay high until the memory side answers with XferAck.
interface window_manager_if #(
    parameter int NWIN = 8
);
    // Requests from the pipeline / trap handler
    logic            Save;
    logic            Restore;
    logic            WrCWP;
    logic [2:0]      CWPIn;
    logic            WrWIM;
    logic [NWIN-1:0] WIMIn;
    // Memory side handshake
    logic            XferAck;
    // Window state and transfer outputs
    logic [2:0]      CWP;
    logic [NWIN-1:0] WIM;
    logic [NWIN-1:0] WinEn;
    logic            Busy;
    logic            TrapOvf;
    logic            TrapUnf;
    logic            SpillReq;
    logic            FillReq;
    logic [2:0]      XferWin;
    logic [4:0]      XferReg;
    logic            XferWE;
    logic            Done;

    modport master (
        output Save, Restore, WrCWP, CWPIn, WrWIM, WIMIn, XferAck,
        input  CWP, WIM, WinEn, Busy, TrapOvf, TrapUnf, SpillReq, FillReq,
               XferWin, XferReg, XferWE, Done
    );

    modport slave (
        input  Save, Restore, WrCWP, CWPIn, WrWIM, WIMIn, XferAck,
        output CWP, WIM, WinEn, Busy, TrapOvf, TrapUnf, SpillReq, FillReq,
               XferWin, XferReg, XferWE, Done
    );
endinterface

// File: rtl/window_manager.sv
// Register-window manager: tracks CWP/WIM, traps on SAVE/RESTORE into an invalid window and spills/fills it.
// Latency: plain SAVE/RESTORE/WrCWP update CWP next edge; a trap takes 1 detect + 16 transfers + 1 commit cycle.
// Backpressure: each transfer word waits for XferAck; new requests are ignored while Busy.
module window_manager #(
    parameter int NWIN = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    window_manager_if.slave  wm
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SPILL  = 2'd1,
        S_FILL   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    localparam logic [NWIN-1:0] WIN_ONE = NWIN'(1);
    localparam logic [NWIN-1:0] WIM_RST = NWIN'(2);
    localparam logic [4:0]      REG_FIRST = 5'd16;
    localparam logic [4:0]      REG_LAST  = 5'd31;

    state_t          state_q, state_d;
    logic [2:0]      cwp_q,   cwp_d;
    logic [NWIN-1:0] wim_q,   wim_d;
    logic [2:0]      tgt_q,   tgt_d;    // window CWP moves to on commit
    logic [2:0]      xwin_q,  xwin_d;   // window being spilled/filled
    logic [4:0]      xreg_q,  xreg_d;
    logic            ovf_q,   ovf_d;
    logic            unf_q,   unf_d;

    // Window index arithmetic, modulo NWIN
    function automatic logic [2:0] win_dec(input logic [2:0] w);
        return (w == 3'd0) ? 3'(NWIN - 1) : w - 3'd1;
    endfunction

    function automatic logic [2:0] win_inc(input logic [2:0] w);
        return (w == 3'(NWIN - 1)) ? 3'd0 : w + 3'd1;
    endfunction

    function automatic logic [2:0] win_wrap(input logic [2:0] w);
        return 3'(int'(w) % NWIN);
    endfunction

    logic [2:0] save_tgt;
    logic [2:0] rest_tgt;
    assign save_tgt = win_dec(cwp_q);
    assign rest_tgt = win_inc(cwp_q);

    // State register with synchronous reset; a reset mid-transfer simply abandons it
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cwp_q   <= 3'd0;
            wim_q   <= WIM_RST;
            tgt_q   <= 3'd0;
            xwin_q  <= 3'd0;
            xreg_q  <= REG_FIRST;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cwp_q   <= cwp_d;
            wim_q   <= wim_d;
            tgt_q   <= tgt_d;
            xwin_q  <= xwin_d;
            xreg_q  <= xreg_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Next-state: request arbitration in IDLE, transfer sequencing, and the commit of CWP/WIM
    always_comb begin
        state_d = state_q;
        cwp_d   = cwp_q;
        wim_d   = wim_q;
        tgt_d   = tgt_q;
        xwin_d  = xwin_q;
        xreg_d  = xreg_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // WIM load is independent of the window move; the trap check below sees the old WIM
                if (wm.WrWIM) begin
                    wim_d = wm.WIMIn;
                end
                if (wm.WrCWP) begin
                    cwp_d = win_wrap(wm.CWPIn);
                end else if (wm.Save && !wm.Restore) begin
                    if (wim_q[save_tgt]) begin
                        ovf_d   = 1'b1;
                        tgt_d   = save_tgt;
                        xwin_d  = win_dec(save_tgt);
                        xreg_d  = REG_FIRST;
                        state_d = S_SPILL;
                    end else begin
                        cwp_d = save_tgt;
                    end
                end else if (wm.Restore && !wm.Save) begin
                    if (wim_q[rest_tgt]) begin
                        unf_d   = 1'b1;
                        tgt_d   = rest_tgt;
                        xwin_d  = win_inc(rest_tgt);
                        xreg_d  = REG_FIRST;
                        state_d = S_FILL;
                    end else begin
                        cwp_d = rest_tgt;
                    end
                end
            end
            S_SPILL, S_FILL: begin
                if (wm.XferAck) begin
                    if (xreg_q == REG_LAST) begin
                        xreg_d  = REG_FIRST;
                        state_d = S_COMMIT;
                    end else begin
                        xreg_d = xreg_q + 5'd1;
                    end
                end
            end
            S_COMMIT: begin
                // The transferred window becomes the new invalid window for both spill and fill
                cwp_d   = tgt_q;
                wim_d   = WIN_ONE << xwin_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign wm.CWP      = cwp_q;
    assign wm.WIM      = wim_q;
    assign wm.WinEn    = WIN_ONE << cwp_q;
    assign wm.Busy     = (state_q != S_IDLE);
    assign wm.TrapOvf  = ovf_q;
    assign wm.TrapUnf  = unf_q;
    assign wm.SpillReq = (state_q == S_SPILL);
    assign wm.FillReq  = (state_q == S_FILL);
    assign wm.XferWin  = xwin_q;
    assign wm.XferReg  = xreg_q;
    assign wm.XferWE   = (state_q == S_FILL) && wm.XferAck;
    assign wm.Done     = (state_q == S_COMMIT);
endmodule

// File: doc/window_manager.md
WINDOW_MANAGER -- requirements
Module: window_manager

Interface
REQ-001 Parameter NWIN, default 8, number of register windows; CWP width fixed at 3 bits, WIM width NWIN.
REQ-002 One clock; reset is synchronous and active-low (Clk, Reset_n).
REQ-003 Clk  in  1  rising-edge clock for all state.
REQ-004 Reset_n  in  1  synchronous active-low reset.
REQ-005 Save  in  1  one-cycle SAVE request (CWP decrement).
REQ-006 Restore  in  1  one-cycle RESTORE request (CWP increment).
REQ-007 WrCWP  in  1; CWPIn  in  3  direct CWP load.
REQ-008 WrWIM  in  1; WIMIn  in  NWIN  direct WIM load.
REQ-009 XferAck  in  1  memory side accepts/supplies current transfer word.
REQ-010 CWP  out  3  current window pointer.
REQ-011 WIM  out  NWIN  window invalid mask.
REQ-012 WinEn  out  NWIN  one-hot decode of CWP, drives per-window block enables.
REQ-013 Busy  out  1  high in any state other than IDLE.
REQ-014 TrapOvf, TrapUnf  out  1 each  one-cycle detection pulses.
REQ-015 SpillReq, FillReq  out  1 each  transfer request, held until XferAck.
REQ-016 XferWin  out  3; XferReg  out  5  window and register index (16..31) of current transfer.
REQ-017 XferWE  out  1  register-file write strobe, = FillReq & XferAck (combinational).
REQ-018 Done  out  1  one-cycle pulse when a spill/fill completes and commits.

Function
REQ-019 States: IDLE, SPILL, FILL, COMMIT; all arithmetic on window indices modulo NWIN.
REQ-020 IDLE priority: WrCWP > Save/Restore; WrCWP loads CWPIn next edge, Save/Restore ignored that cycle.
REQ-021 WrWIM accepted only in IDLE, independent of Save/Restore/WrCWP; WIM check that cycle uses the old WIM.
REQ-022 Save and Restore asserted together in IDLE: both ignored, no state change.
REQ-023 Save, target N=CWP-1, WIM[N]=0: CWP<=N next edge, no trap, state stays IDLE.
REQ-024 Save, WIM[N]=1: TrapOvf pulse, latch N, go SPILL with XferWin=N-1, XferReg=16.
REQ-025 Restore, target N=CWP+1, WIM[N]=0: CWP<=N next edge.
REQ-026 Restore, WIM[N]=1: TrapUnf pulse, latch N, go FILL with XferWin=N+1, XferReg=16.
REQ-027 SPILL/FILL: Req held high, XferWin/XferReg stable until XferAck; each ack increments XferReg.
REQ-028 Ack with XferReg=31 -> COMMIT; exactly 16 transfers per trap.
REQ-029 COMMIT (1 cycle): CWP<=latched N; WIM<=one-hot at N-1 (spill) or N+1 (fill); Done pulse; -> IDLE.
REQ-030 Save/Restore/WrCWP/WrWIM ignored while Busy; XferAck ignored in IDLE and COMMIT.
REQ-031 Overflow latency 18 cycles minimum (detect, 16 acked transfers, commit) with XferAck tied high.
REQ-032 WinEn and CWP update on the same edge; WinEn never zero or multi-hot.

Reset
REQ-033 Reset_n low at a rising edge: state IDLE, CWP=0, WIM=NWIN'h02, all Req/trap/Done/XferWE=0, XferReg=16, XferWin=0.
REQ-034 Reset mid-SPILL/FILL aborts transfer immediately; CWP/WIM take reset values, no Done pulse.

Verification
REQ-035 After reset, 6 Saves -> CWP 7,6,5,4,3,2, no trap; 7th Save -> TrapOvf, SpillReq, XferWin=0.
REQ-036 Spill with XferAck high 16 cycles -> XferReg 16..31, Done, CWP=1, WIM=8'h01.
REQ-037 From CWP=0, WIM=8'h02, Restore -> TrapUnf, FillReq, XferWin=2; 16 acks -> 16 XferWE pulses, CWP=1, WIM=8'h04.
REQ-038 XferAck withheld 5 cycles mid-spill -> SpillReq, XferWin, XferReg held constant.
REQ-039 Save+WrCWP (CWPIn=5) same cycle -> CWP=5, no trap; Save+Restore together -> CWP unchanged.
REQ-040 Reset_n low during FILL at XferReg=20 -> next cycle IDLE, CWP=0, WIM=8'h02, FillReq=0.
